// File: rtl/div_pkg.sv
// Shared types and constants for the shift/subtract restoring divider.
package div_pkg;

    localparam int DIV_WIDTH   = 8;
    localparam int DIV_CNT_MAX = DIV_WIDTH - 1;
    localparam int DIV_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_control.sv
// Control FSM for the restoring divider: sequences one shift/subtract pair per
// quotient bit and decodes datapath strobes and status flags from state.
module div_control
    import div_pkg::*;
#(
    parameter int CNT_MAX = DIV_CNT_MAX
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_div_zero,
    output logic o_load,
    output logic o_load_zero,
    output logic o_shift,
    output logic o_sub,
    output logic o_busy,
    output logic o_done
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(CNT_MAX);

    div_state_t             r_state;
    div_state_t             w_next;
    logic [DIV_CNT_W-1:0]   r_cnt;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Iteration counter: cleared on a normal start, advanced once per subtract step
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {DIV_CNT_W{1'b0}};
        end else if (o_load) begin
            r_cnt <= {DIV_CNT_W{1'b0}};
        end else if (o_sub) begin
            r_cnt <= r_cnt + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next      = r_state;
        o_load      = 1'b0;
        o_load_zero = 1'b0;
        o_shift     = 1'b0;
        o_sub       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    if (i_div_zero) begin
                        o_load_zero = 1'b1;
                        w_next      = DONE;
                    end else begin
                        o_load = 1'b1;
                        w_next = SHIFT;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            SHIFT: begin
                o_shift = 1'b1;
                w_next  = SUB;
            end
            SUB: begin
                o_sub = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next = DONE;
                end else begin
                    w_next = SHIFT;
                end
            end
            DONE: begin
                // Run must be released before another operation can start
                if (i_run) begin
                    w_next = DONE;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign o_busy = (r_state == SHIFT) || (r_state == SUB);
    assign o_done = (r_state == DONE);

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: 9-bit partial remainder, quotient
// register, and a 10-bit trial subtract whose MSB acts as the borrow-out.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_div_zero;
    logic [WIDTH+1:0] w_trial;
    logic             w_div_zero;
    logic             w_load;
    logic             w_load_zero;
    logic             w_shift;
    logic             w_sub;

    assign w_div_zero = (Divisor == {WIDTH{1'b0}});
    assign w_trial    = {1'b0, r_rem} - {2'b00, r_div};

    div_control #(
        .CNT_MAX (WIDTH - 1)
    ) u_control (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_run       (Run),
        .i_div_zero  (w_div_zero),
        .o_load      (w_load),
        .o_load_zero (w_load_zero),
        .o_shift     (w_shift),
        .o_sub       (w_sub),
        .o_busy      (Busy),
        .o_done      (Done)
    );

    // Datapath registers: operand capture, shift, and restoring subtract
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rem      <= {(WIDTH+1){1'b0}};
            r_quo      <= {WIDTH{1'b0}};
            r_div      <= {WIDTH{1'b0}};
            r_div_zero <= 1'b0;
        end else if (w_load) begin
            r_rem      <= {(WIDTH+1){1'b0}};
            r_quo      <= Dividend;
            r_div      <= Divisor;
            r_div_zero <= 1'b0;
        end else if (w_load_zero) begin
            // Divide-by-zero reports all-ones quotient and passes the dividend through
            r_rem      <= {1'b0, Dividend};
            r_quo      <= {WIDTH{1'b1}};
            r_div_zero <= 1'b1;
        end else if (w_shift) begin
            {r_rem, r_quo} <= {r_rem[WIDTH-1:0], r_quo, 1'b0};
        end else if (w_sub) begin
            if (!w_trial[WIDTH+1]) begin
                r_rem    <= w_trial[WIDTH:0];
                r_quo[0] <= 1'b1;
            end else begin
                r_quo[0] <= 1'b0;
            end
        end else begin
            r_rem <= r_rem;
        end
    end

    assign Quotient  = r_quo;
    assign Remainder = r_rem[WIDTH-1:0];
    assign DivZero   = r_div_zero;

endmodule
